// File: rtl/line_buffer_ctrl_pkg.sv
// Shared constants and state type for the scanline ping-pong buffer controller.
package line_buffer_pkg;

  localparam int DEPTH_DEFAULT = 512;
  localparam int SKEW_DEFAULT  = 9;
  localparam int MASK_DEFAULT  = 8;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    FILL,
    RUN
  } ctrl_state_t;

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Sync inputs, runtime config and bank/address outputs of the line buffer controller.
interface line_buffer_ctrl_if
  import line_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              hsync;
    logic              vsync;
    logic [ADDR_W-1:0] cfg_skew;
    logic [ADDR_W-1:0] cfg_mask;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_mask;
    logic              out_valid;
    logic [ADDR_W:0]   line_len;
    logic              ovf;
    logic              frame_start;

    // Controller side.
    modport slave (
        input  hsync, vsync, cfg_skew, cfg_mask,
        output wr_en, wr_bank, wr_addr, rd_bank, rd_addr, rd_mask,
        output out_valid, line_len, ovf, frame_start
    );

    // Timing source / pixel path side.
    modport master (
        output hsync, vsync, cfg_skew, cfg_mask,
        input  wr_en, wr_bank, wr_addr, rd_bank, rd_addr, rd_mask,
        input  out_valid, line_len, ovf, frame_start
    );

endinterface

// File: rtl/line_buffer_ctrl_sync_edge_det.sv
// Rising-edge detector: registers the previous sample, flags din high after a low sample.
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic last;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b0;
        end else begin
            last <= din;
        end
    end

    assign rise = din & ~last;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Ping-pong scanline buffer sequencer: bank select, write/read addressing, skew, mask, overflow.
module line_buffer_ctrl
  import line_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    line_buffer_ctrl_if.slave  bus
);

    localparam int              ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST   = (ADDR_W + 1)'(DEPTH - 1);

    logic [ADDR_W:0] index;
    logic [ADDR_W:0] line_len_q;
    logic            bank;
    logic            ovf_q;
    logic            frame_q;
    ctrl_state_t     state;
    logic            h_rise;
    logic            v_rise;

    sync_edge_det u_hsync_det (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.hsync),
        .rise    (h_rise)
    );

    sync_edge_det u_vsync_det (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.vsync),
        .rise    (v_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index      <= '0;
            line_len_q <= '0;
            bank       <= 1'b0;
            ovf_q      <= 1'b0;
            frame_q    <= 1'b0;
            state      <= WAIT_SYNC;
        end else begin
            frame_q <= v_rise;
            if (h_rise) begin
                // The edge-cycle pixel was written at the old index, hence the +1.
                line_len_q <= (index == FULL) ? FULL : index + 1'b1;
                index      <= '0;
                bank       <= ~bank;
                ovf_q      <= 1'b0;
                case (state)
                    WAIT_SYNC: state <= FILL;
                    FILL:      state <= RUN;
                    default:   state <= RUN;
                endcase
            end else begin
                // Saturate at DEPTH; overflow asserts the cycle index lands there.
                if (index != FULL) begin
                    index <= index + 1'b1;
                end
                ovf_q <= (index >= LAST);
            end
        end
    end

    logic valid;
    assign valid = (state == RUN);

    assign bus.wr_en       = (state != WAIT_SYNC) && !ovf_q;
    assign bus.wr_bank     = bank;
    assign bus.rd_bank     = ~bank;
    assign bus.wr_addr     = index[ADDR_W-1:0];
    // Truncation to ADDR_W bits gives the wrap modulo DEPTH.
    assign bus.rd_addr     = index[ADDR_W-1:0] + bus.cfg_skew;
    assign bus.rd_mask     = (index < {1'b0, bus.cfg_mask}) || !valid;
    assign bus.out_valid   = valid;
    assign bus.line_len    = line_len_q;
    assign bus.ovf         = ovf_q;
    assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: cycle-level model comparison plus literal anchor checks.
module tb_line_buffer_ctrl;
    import line_buffer_pkg::*;

    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int AW    = $clog2(DEPTH);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    line_buffer_ctrl_if #(.DEPTH(DEPTH)) bus ();

    line_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: clocks since line start, edges seen, last line length.
    int m_cyc   = 0;
    int m_edges = 0;
    int m_len   = 0;
    bit m_fs    = 1'b0;
    bit m_ph    = 1'b0;
    bit m_pv    = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc   = 0;
            m_edges = 0;
            m_len   = 0;
            m_fs    = 1'b0;
            m_ph    = 1'b0;
            m_pv    = 1'b0;
        end else begin
            m_fs = bus.vsync && !m_pv;
            if (bus.hsync && !m_ph) begin
                m_len   = (m_cyc + 1 > DEPTH) ? DEPTH : m_cyc + 1;
                m_cyc   = 0;
                m_edges = m_edges + 1;
            end else begin
                m_cyc = m_cyc + 1;
            end
            m_ph = bus.hsync;
            m_pv = bus.vsync;
        end
    end

    always @(negedge clk) begin : cmp_blk
        int idx;
        idx = (m_cyc < DEPTH) ? m_cyc : DEPTH;
        check("m_wr_addr",     32'(bus.wr_addr),     idx % DEPTH);
        check("m_wr_bank",     32'(bus.wr_bank),     m_edges % 2);
        check("m_rd_bank",     32'(bus.rd_bank),     1 - (m_edges % 2));
        check("m_out_valid",   32'(bus.out_valid),   32'(m_edges >= 2));
        check("m_wr_en",       32'(bus.wr_en),       32'(m_edges >= 1 && m_cyc < DEPTH));
        check("m_ovf",         32'(bus.ovf),         32'(m_cyc >= DEPTH));
        check("m_rd_addr",     32'(bus.rd_addr),     (idx + int'(bus.cfg_skew)) % DEPTH);
        check("m_rd_mask",     32'(bus.rd_mask),     32'(idx < int'(bus.cfg_mask) || m_edges < 2));
        check("m_line_len",    32'(bus.line_len),    m_len);
        check("m_frame_start", 32'(bus.frame_start), 32'(m_fs));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_tick();
        bus.hsync = 1'b1;
        tick();
        bus.hsync = 1'b0;
    endtask

    initial begin
        bus.hsync    = 1'b0;
        bus.vsync    = 1'b0;
        bus.cfg_skew = AW'(SKEW_DEFAULT);
        bus.cfg_mask = AW'(MASK_DEFAULT);
        #12;
        check("rst_wr_en",       32'(bus.wr_en),       0);
        check("rst_out_valid",   32'(bus.out_valid),   0);
        check("rst_rd_mask",     32'(bus.rd_mask),     1);
        check("rst_wr_addr",     32'(bus.wr_addr),     0);
        check("rst_rd_addr",     32'(bus.rd_addr),     9);
        check("rst_line_len",    32'(bus.line_len),    0);
        check("rst_frame_start", 32'(bus.frame_start), 0);
        check("rst_wr_bank",     32'(bus.wr_bank),     0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Three lines of 400 clocks: FILL after first edge, RUN after second.
        repeat (399) tick();
        check("wait_wr_addr", 32'(bus.wr_addr), 399);
        edge_tick();
        check("e1_wr_bank",   32'(bus.wr_bank),   1);
        check("e1_wr_addr",   32'(bus.wr_addr),   0);
        check("e1_line_len",  32'(bus.line_len),  400);
        check("e1_out_valid", 32'(bus.out_valid), 0);
        check("e1_wr_en",     32'(bus.wr_en),     1);
        repeat (399) tick();
        edge_tick();
        check("e2_wr_bank",   32'(bus.wr_bank),   0);
        check("e2_out_valid", 32'(bus.out_valid), 1);
        check("e2_line_len",  32'(bus.line_len),  400);
        repeat (399) tick();
        edge_tick();
        check("e3_wr_bank",   32'(bus.wr_bank),   1);
        check("e3_line_len",  32'(bus.line_len),  400);

        // Skew and mask at line start, wrap near the end, then overflow on a 600-clock line.
        check("i0_rd_addr", 32'(bus.rd_addr), 9);
        check("i0_rd_mask", 32'(bus.rd_mask), 1);
        repeat (7) tick();
        check("i7_rd_addr", 32'(bus.rd_addr), 16);
        check("i7_rd_mask", 32'(bus.rd_mask), 1);
        tick();
        check("i8_rd_addr", 32'(bus.rd_addr), 17);
        check("i8_rd_mask", 32'(bus.rd_mask), 0);
        repeat (502) tick();
        check("i510_rd_addr", 32'(bus.rd_addr), 7);
        check("i510_ovf",     32'(bus.ovf),     0);
        tick();
        check("i511_wr_en",   32'(bus.wr_en),   1);
        check("i511_wr_addr", 32'(bus.wr_addr), 511);
        tick();
        check("i512_ovf",     32'(bus.ovf),     1);
        check("i512_wr_en",   32'(bus.wr_en),   0);
        check("i512_rd_addr", 32'(bus.rd_addr), 9);
        repeat (87) tick();
        check("i599_ovf", 32'(bus.ovf), 1);
        edge_tick();
        check("e4_line_len", 32'(bus.line_len), 512);
        check("e4_ovf",      32'(bus.ovf),      0);
        check("e4_wr_en",    32'(bus.wr_en),    1);
        check("e4_wr_bank",  32'(bus.wr_bank),  0);

        // Live config change mid-line.
        repeat (3) tick();
        check("cfg_mask_before", 32'(bus.rd_mask), 1);
        bus.cfg_mask = '0;
        #1;
        check("cfg_mask_now", 32'(bus.rd_mask), 0);
        tick();
        check("cfg_mask_next", 32'(bus.rd_mask), 0);
        bus.cfg_skew = AW'(20);
        #1;
        check("cfg_skew_now", 32'(bus.rd_addr), 24);
        bus.cfg_skew = AW'(SKEW_DEFAULT);
        bus.cfg_mask = AW'(MASK_DEFAULT);
        repeat (95) tick();

        // Coincident hsync and vsync edges; vsync held high must not re-pulse.
        bus.vsync = 1'b1;
        edge_tick();
        check("fs_pulse",    32'(bus.frame_start), 1);
        check("fs_wr_bank",  32'(bus.wr_bank),     1);
        check("fs_line_len", 32'(bus.line_len),    100);
        check("fs_wr_addr",  32'(bus.wr_addr),     0);
        tick();
        check("fs_drop", 32'(bus.frame_start), 0);
        tick();
        bus.vsync = 1'b0;
        tick();
        check("fs_low", 32'(bus.frame_start), 0);

        // Reset mid-line in RUN at index 200.
        repeat (197) tick();
        check("pre_rst_wr_addr", 32'(bus.wr_addr), 200);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_addr",   32'(bus.wr_addr),   0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_wr_en",     32'(bus.wr_en),     0);
        check("mid_rst_wr_bank",   32'(bus.wr_bank),   0);
        tick();
        reset_n = 1'b1;

        // hsync held high produces only one edge; two edges needed to reach RUN again.
        bus.hsync = 1'b1;
        tick();
        repeat (4) tick();
        check("hold_wr_addr",   32'(bus.wr_addr),   4);
        check("hold_wr_bank",   32'(bus.wr_bank),   1);
        check("hold_out_valid", 32'(bus.out_valid), 0);
        bus.hsync = 1'b0;
        repeat (45) tick();
        edge_tick();
        check("re_out_valid", 32'(bus.out_valid), 1);
        check("re_line_len",  32'(bus.line_len),  50);
        check("re_wr_bank",   32'(bus.wr_bank),   0);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
